// File: rtl/stack_unit_if.sv
// Command/response bundle for stack_unit: push/pop/tos commands, read data and
// status flags. The master drives commands; the slave (the stack) returns results.
interface stack_unit_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic             push;
    logic             pop;
    logic             tos;
    logic             clr_err;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output push, pop, tos, clr_err, din,
        input  dout, dout_valid, count, empty, full, overflow, underflow
    );

    modport slave (
        input  push, pop, tos, clr_err, din,
        output dout, dout_valid, count, empty, full, overflow, underflow
    );
endinterface

// File: rtl/stack_unit.sv
// LIFO stack with a registered read port, push/pop/tos commands, replace-top on
// simultaneous push+pop, and sticky overflow/underflow flags.
module stack_unit #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst,
    stack_unit_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_PART  = 2'd1,
        S_FULL  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    cnt_next_s;
    logic [CW-1:0]    cnt_dec_s;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             is_empty_s;
    logic             is_full_s;
    logic [AW-1:0]    sp_s;
    logic [AW-1:0]    top_s;
    logic [AW-1:0]    wr_addr_s;
    logic             wr_en_s;
    logic             rd_en_s;
    logic             ovf_set_s;
    logic             udf_set_s;

    assign is_empty_s = (state_r == S_EMPTY);
    assign is_full_s  = (state_r == S_FULL);
    assign cnt_dec_s  = count_r - {{(CW-1){1'b0}}, 1'b1};
    assign sp_s       = count_r[AW-1:0];
    assign top_s      = cnt_dec_s[AW-1:0];

    // Command decode: every rejected command leaves memory/count alone and only raises a flag.
    always_comb begin
        wr_en_s    = 1'b0;
        wr_addr_s  = sp_s;
        rd_en_s    = 1'b0;
        cnt_next_s = count_r;
        ovf_set_s  = 1'b0;
        udf_set_s  = 1'b0;
        if (bus.push && bus.pop) begin
            if (!is_empty_s) begin
                rd_en_s   = 1'b1;
                wr_en_s   = 1'b1;
                wr_addr_s = top_s;
            end else begin
                wr_en_s    = 1'b1;
                cnt_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                udf_set_s  = 1'b1;
            end
        end else if (bus.pop) begin
            if (!is_empty_s) begin
                rd_en_s    = 1'b1;
                cnt_next_s = cnt_dec_s;
            end else begin
                udf_set_s = 1'b1;
            end
        end else if (bus.push) begin
            // A tos riding along with a push reads the old top before the push lands.
            if (bus.tos && !is_empty_s) begin
                rd_en_s = 1'b1;
            end else if (bus.tos) begin
                udf_set_s = 1'b1;
            end else begin
                rd_en_s = 1'b0;
            end
            if (!is_full_s) begin
                wr_en_s    = 1'b1;
                cnt_next_s = count_r + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                ovf_set_s = 1'b1;
            end
        end else if (bus.tos) begin
            if (!is_empty_s) begin
                rd_en_s = 1'b1;
            end else begin
                udf_set_s = 1'b1;
            end
        end else begin
            cnt_next_s = count_r;
        end
    end

    // Occupancy state follows the next count so empty/full come straight from a register.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_EMPTY, S_PART, S_FULL: begin
                if (cnt_next_s == CW'(0)) begin
                    state_s = S_EMPTY;
                end else if (cnt_next_s == CW'(DEPTH)) begin
                    state_s = S_FULL;
                end else begin
                    state_s = S_PART;
                end
            end
            default: state_s = S_EMPTY;
        endcase
    end

    // Control, read-port and flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= S_EMPTY;
            count_r      <= '0;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            overflow_r   <= 1'b0;
            underflow_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            count_r      <= cnt_next_s;
            dout_valid_r <= rd_en_s;
            if (rd_en_s) begin
                dout_r <= mem_r[top_s];
            end
            if (ovf_set_s) begin
                overflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                overflow_r <= 1'b0;
            end
            if (udf_set_s) begin
                underflow_r <= 1'b1;
            end else if (bus.clr_err) begin
                underflow_r <= 1'b0;
            end
        end
    end

    // Storage is not reset; a write coinciding with reset is dropped.
    always_ff @(posedge clk) begin
        if (wr_en_s && !rst) begin
            mem_r[wr_addr_s] <= bus.din;
        end
    end

    assign bus.dout       = dout_r;
    assign bus.dout_valid = dout_valid_r;
    assign bus.count      = count_r;
    assign bus.empty      = is_empty_s;
    assign bus.full       = is_full_s;
    assign bus.overflow   = overflow_r;
    assign bus.underflow  = underflow_r;
endmodule

// File: tb/tb_stack_unit.sv
// Directed self-checking bench for stack_unit (WIDTH=8, DEPTH=16) with
// hand-computed expectations.
module tb_stack_unit;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_fails;

    stack_unit_if #(.WIDTH(8), .DEPTH(16)) bus ();

    stack_unit #(.WIDTH(8), .DEPTH(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one command for one rising edge, then return to idle 1 time unit later.
    task automatic cmd(input logic p, input logic o, input logic t, input logic c, input logic [7:0] d);
        bus.push = p; bus.pop = o; bus.tos = t; bus.clr_err = c; bus.din = d;
        @(posedge clk);
        #1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.clr_err = 1'b0; bus.din = 8'h00;
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        clk = 1'b0;
        rst = 1'b1;
        bus.push = 1'b0; bus.pop = 1'b0; bus.tos = 1'b0; bus.clr_err = 1'b0; bus.din = 8'h00;
        #22;
        check_eq("rst_count", 32'(bus.count), 32'd0);
        check_eq("rst_empty", 32'(bus.empty), 32'd1);
        check_eq("rst_full", 32'(bus.full), 32'd0);
        check_eq("rst_dout", 32'(bus.dout), 32'h00);
        check_eq("rst_dv", 32'(bus.dout_valid), 32'd0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'd0);
        check_eq("rst_udf", 32'(bus.underflow), 32'd0);
        rst = 1'b0;

        // LIFO order
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h11);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h22);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h33);
        check_eq("push3_count", 32'(bus.count), 32'd3);
        check_eq("push_dv", 32'(bus.dout_valid), 32'd0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("pop1_dout", 32'(bus.dout), 32'h33);
        check_eq("pop1_dv", 32'(bus.dout_valid), 32'd1);
        check_eq("pop1_count", 32'(bus.count), 32'd2);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("pop2_dout", 32'(bus.dout), 32'h22);
        check_eq("pop2_dv", 32'(bus.dout_valid), 32'd1);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("pop3_dout", 32'(bus.dout), 32'h11);
        check_eq("pop3_dv", 32'(bus.dout_valid), 32'd1);
        check_eq("pop3_count", 32'(bus.count), 32'd0);
        check_eq("pop3_empty", 32'(bus.empty), 32'd1);
        cmd(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check_eq("idle_dv", 32'(bus.dout_valid), 32'd0);
        check_eq("idle_dout_hold", 32'(bus.dout), 32'h11);

        // Underflow on empty
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("epop_udf", 32'(bus.underflow), 32'd1);
        check_eq("epop_dv", 32'(bus.dout_valid), 32'd0);
        check_eq("epop_dout", 32'(bus.dout), 32'h11);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("etos_udf", 32'(bus.underflow), 32'd1);
        check_eq("etos_dv", 32'(bus.dout_valid), 32'd0);
        check_eq("etos_count", 32'(bus.count), 32'd0);
        cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check_eq("set_wins_clr", 32'(bus.underflow), 32'd1);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_eq("clr_udf", 32'(bus.underflow), 32'd0);

        // Fill to full, then overflow
        for (int i = 0; i < 16; i++) begin
            cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'(i));
        end
        check_eq("fill_full", 32'(bus.full), 32'd1);
        check_eq("fill_count", 32'(bus.count), 32'd16);
        check_eq("fill_ovf", 32'(bus.overflow), 32'd0);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'hAA);
        check_eq("ovf_set", 32'(bus.overflow), 32'd1);
        check_eq("ovf_count", 32'(bus.count), 32'd16);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("full_pop_dout", 32'(bus.dout), 32'h0F);
        check_eq("full_pop_count", 32'(bus.count), 32'd15);
        check_eq("full_pop_full", 32'(bus.full), 32'd0);
        cmd(1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        check_eq("clr_ovf", 32'(bus.overflow), 32'd0);

        // Replace-top while full
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h0F);
        cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h55);
        check_eq("frep_dout", 32'(bus.dout), 32'h0F);
        check_eq("frep_count", 32'(bus.count), 32'd16);
        check_eq("frep_ovf", 32'(bus.overflow), 32'd0);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("frep_new_top", 32'(bus.dout), 32'h55);

        // Push+pop on empty pushes and flags underflow
        rst = 1'b1;
        #2;
        rst = 1'b0;
        cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h3C);
        check_eq("epp_count", 32'(bus.count), 32'd1);
        check_eq("epp_udf", 32'(bus.underflow), 32'd1);
        check_eq("epp_dv", 32'(bus.dout_valid), 32'd0);
        cmd(1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
        check_eq("epp_pop", 32'(bus.dout), 32'h3C);

        // Replace-top, tos, push+tos, pop+tos
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h05);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h07);
        cmd(1'b1, 1'b1, 1'b0, 1'b0, 8'h09);
        check_eq("rep_dout", 32'(bus.dout), 32'h07);
        check_eq("rep_count", 32'(bus.count), 32'd2);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("tos_dout", 32'(bus.dout), 32'h09);
        check_eq("tos_dv", 32'(bus.dout_valid), 32'd1);
        check_eq("tos_count", 32'(bus.count), 32'd2);
        cmd(1'b1, 1'b0, 1'b1, 1'b0, 8'h0A);
        check_eq("ptos_dout", 32'(bus.dout), 32'h09);
        check_eq("ptos_count", 32'(bus.count), 32'd3);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("ptos_pop", 32'(bus.dout), 32'h0A);
        cmd(1'b0, 1'b1, 1'b1, 1'b0, 8'h00);
        check_eq("poptos_dout", 32'(bus.dout), 32'h09);
        check_eq("poptos_count", 32'(bus.count), 32'd1);

        // Asynchronous reset mid-burst at count=5
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h61);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h62);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h63);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h64);
        cmd(1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        check_eq("burst_count", 32'(bus.count), 32'd5);
        check_eq("burst_dout", 32'(bus.dout), 32'h64);
        #2;
        rst = 1'b1;
        #1;
        check_eq("arst_count", 32'(bus.count), 32'd0);
        check_eq("arst_empty", 32'(bus.empty), 32'd1);
        check_eq("arst_dout", 32'(bus.dout), 32'h00);
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'hEE);
        check_eq("rst_push_dropped", 32'(bus.count), 32'd0);
        rst = 1'b0;
        cmd(1'b1, 1'b0, 1'b0, 1'b0, 8'h77);
        check_eq("post_rst_count", 32'(bus.count), 32'd1);
        cmd(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        check_eq("post_rst_pop", 32'(bus.dout), 32'h77);
        check_eq("post_rst_empty", 32'(bus.empty), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/stack_unit.md
STACK_UNIT -- requirements
Module: stack_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 16: stack capacity in words; power of two, at least 2.
REQ-003 SHALL have input clk, 1 bit: single clock; all state updates on the rising edge.
REQ-004 SHALL have input rst, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have input push, 1 bit: write din onto the stack.
REQ-006 SHALL have input pop, 1 bit: remove the top word and return it on dout.
REQ-007 SHALL have input tos, 1 bit: read the top word onto dout without removing it.
REQ-008 SHALL have input clr_err, 1 bit: clear the sticky error flags.
REQ-009 SHALL have input din, WIDTH bits: push data.
REQ-010 SHALL have output dout, WIDTH bits: registered read data.
REQ-011 SHALL have output dout_valid, 1 bit: one-cycle pulse; dout holds newly read data.
REQ-012 SHALL have output count, log2(DEPTH)+1 bits: current occupancy.
REQ-013 SHALL have output empty, 1 bit: high when count = 0.
REQ-014 SHALL have output full, 1 bit: high when count = DEPTH.
REQ-015 SHALL have output overflow, 1 bit: sticky; set by a push rejected while full.
REQ-016 SHALL have output underflow, 1 bit: sticky; set by a pop or tos rejected while empty.

Function
REQ-017 SHALL hold the words in a DEPTH x WIDTH register array, addressed by stack pointer sp, where sp = count. The top word is at mem[sp-1].
REQ-018 SHALL track occupancy as 3 states: S_EMPTY (count=0), S_PART (0<count<DEPTH) and S_FULL (count=DEPTH). empty and full SHALL be decoded from the state register, not from combinational input paths.
REQ-019 On push alone, when not full: mem[sp] <= din and count <= count+1, both at the next edge. dout SHALL be unchanged and dout_valid SHALL be 0.
REQ-020 On pop alone, when not empty: dout <= mem[sp-1], count <= count-1 and dout_valid <= 1, all at the next edge. Latency is 1 cycle.
REQ-021 On tos alone, when not empty: dout <= mem[sp-1] and dout_valid <= 1. count SHALL be unchanged.
REQ-022 If pop and tos are both high, the unit SHALL behave as pop; tos is ignored.
REQ-023 If push and pop are both high and the stack is not empty, the unit SHALL replace the top:
- dout <= old mem[sp-1] and dout_valid <= 1;
- mem[sp-1] <= din;
- count unchanged.
This also applies when the stack is full, and SHALL NOT set overflow.
REQ-024 If push and pop are both high and the stack is empty, the unit SHALL do the push per REQ-019 and set underflow. dout_valid SHALL be 0.
REQ-025 If push and tos are both high and the stack is not empty: dout <= old top and dout_valid <= 1, then the push SHALL proceed per REQ-019 if the stack is not full.
REQ-026 A push while full, with no pop, SHALL leave memory and count unchanged and set overflow.
REQ-027 A pop or tos while empty, with no push, SHALL leave dout and count unchanged, hold dout_valid at 0, and set underflow.
REQ-028 An error set and clr_err in the same cycle: set SHALL win. clr_err alone SHALL clear both flags at the next edge.
REQ-029 dout_valid SHALL be high for exactly one cycle per accepted read. dout SHALL hold its value until the next accepted read.
REQ-030 count SHALL never wrap. The pointer arithmetic SHALL use log2(DEPTH)+1 bits so that count = DEPTH is representable.

Reset
REQ-031 While rst is high, the unit SHALL asynchronously force:
- count = 0 and state = S_EMPTY;
- empty = 1, full = 0;
- dout = 0, dout_valid = 0;
- overflow = 0, underflow = 0.
REQ-032 Memory contents SHALL NOT be reset. After reset they are unobservable because the stack is empty.
REQ-033 Reset asserted mid-operation SHALL discard any push, pop or tos sampled in that cycle. No write SHALL occur.
REQ-034 After rst is released, the first rising edge SHALL accept commands normally.

Verification (WIDTH=8, DEPTH=16)
REQ-035 SHALL cover: push 0x11, 0x22, 0x33 on consecutive cycles, then pop x3 -> dout 0x33, 0x22, 0x11 each 1 cycle after its pop, dout_valid high 3 cycles, count 3->0, empty=1.
REQ-036 SHALL cover: push 16 words 0x00..0x0F -> full=1, count=16; a 17th push of 0xAA -> overflow=1, count=16; pop -> dout=0x0F.
REQ-037 SHALL cover: pop, then tos, on an empty stack -> underflow=1, dout_valid=0, count=0; clr_err pulse -> underflow=0.
REQ-038 SHALL cover: stack holding [0x05, 0x07 top], push+pop with din=0x09 -> dout=0x07, count=2; tos -> dout=0x09.
REQ-039 SHALL cover: full stack, push+pop with din=0x55 -> dout=old top, count=16, overflow=0.
REQ-040 SHALL cover: rst asserted asynchronously mid-burst at count=5 -> count=0, empty=1 and dout=0 immediately, without waiting for a clk edge.
